// File: rtl/src_video_window_pkg.sv
// Shared types and defaults for the source-side video window front end.
package src_video_window_pkg;

  localparam int unsigned CNT_W_DEFAULT = 12;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_PASS = 1'b1
  } vid_state_e;

endpackage

// File: rtl/vid_timing_meas.sv
// Stage-1 timing tracker: sync/de edge detection, pixel and line counters, and
// per-frame resolution measurement with a line-length consistency check.
module vid_timing_meas #(
  parameter int unsigned P_CNT_W = 12
) (
  input  logic               i_src_clk,
  input  logic               i_rst_n,
  input  logic               i_vs,
  input  logic               i_de,
  output logic               o_vs_fall,
  output logic [P_CNT_W-1:0] o_x,
  output logic [P_CNT_W-1:0] o_y,
  output logic [P_CNT_W-1:0] o_h_active,
  output logic [P_CNT_W-1:0] o_v_active,
  output logic               o_frame_err
);

  localparam logic [P_CNT_W-1:0] CntMax = '1;
  localparam logic [P_CNT_W-1:0] CntOne = P_CNT_W'(1);

  logic               vs_q, de_q;
  logic               vs_rise, de_fall, line_err;
  logic [P_CNT_W-1:0] x_q, y_q, x_inc, y_inc;
  logic [P_CNT_W-1:0] ref_len_q, last_len_q;
  logic               have_ref_q, err_acc_q;

  assign o_vs_fall = vs_q & ~i_vs;
  assign vs_rise   = ~vs_q & i_vs;
  assign de_fall   = de_q & ~i_de;

  assign x_inc    = (x_q == CntMax) ? x_q : x_q + CntOne;
  assign y_inc    = (y_q == CntMax) ? y_q : y_q + CntOne;
  assign line_err = have_ref_q & (x_q != ref_len_q);

  assign o_x = x_q;
  assign o_y = y_q;

  always_ff @(posedge i_src_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ref_len_q   <= '0;
      last_len_q  <= '0;
      have_ref_q  <= 1'b0;
      err_acc_q   <= 1'b0;
      o_h_active  <= '0;
      o_v_active  <= '0;
      o_frame_err <= 1'b0;
    end else begin
      vs_q <= i_vs;
      de_q <= i_de;

      if (de_fall) begin
        x_q <= '0;
      end else if (i_de) begin
        x_q <= x_inc;
      end

      if (o_vs_fall) begin
        y_q <= '0;
      end else if (de_fall) begin
        y_q <= y_inc;
      end

      if (o_vs_fall) begin
        have_ref_q <= 1'b0;
        last_len_q <= '0;
      end else if (de_fall) begin
        last_len_q <= x_q;
        if (!have_ref_q) begin
          ref_len_q  <= x_q;
          have_ref_q <= 1'b1;
        end
      end

      if (vs_rise) begin
        err_acc_q <= 1'b0;
      end else if (de_fall && line_err) begin
        err_acc_q <= 1'b1;
      end

      // A line ending on the same cycle as frame end is folded into the result.
      if (vs_rise) begin
        o_h_active  <= de_fall ? x_q : last_len_q;
        o_v_active  <= de_fall ? y_inc : y_q;
        o_frame_err <= err_acc_q | (de_fall & line_err);
      end
    end
  end

endmodule

// File: rtl/src_video_window.sv
// Source-clock video front end: normalises vsync, starts capture only on a frame
// boundary, crops a per-frame window and reports the measured input resolution.
module src_video_window
  import src_video_window_pkg::*;
#(
  parameter bit          P_VS_POL = 1'b1,
  parameter int unsigned P_CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned P_DATA_W = 24
) (
  input  logic                i_src_clk,
  input  logic                i_rst_n,
  input  logic                i_vid_vsyn,
  input  logic                i_vid_de,
  input  logic [P_DATA_W-1:0] i_vid_data,
  input  logic                i_enable,
  input  logic [P_CNT_W-1:0]  i_x_start,
  input  logic [P_CNT_W-1:0]  i_x_size,
  input  logic [P_CNT_W-1:0]  i_y_start,
  input  logic [P_CNT_W-1:0]  i_y_size,
  output logic                o_src_vsyn,
  output logic                o_src_de,
  output logic [P_DATA_W-1:0] o_src_data,
  output logic                o_frame_active,
  output logic [P_CNT_W-1:0]  o_h_active,
  output logic [P_CNT_W-1:0]  o_v_active,
  output logic                o_frame_err
);

  logic                vs1_q, de1_q;
  logic [P_DATA_W-1:0] data1_q;
  logic                vs_fall;
  logic [P_CNT_W-1:0]  x, y;
  logic [P_CNT_W-1:0]  xs_q, xsz_q, ys_q, ysz_q;
  logic [P_CNT_W:0]    x_end, y_end;
  logic                in_win, de_win;
  vid_state_e          state_q, state_d;

  always_ff @(posedge i_src_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs1_q   <= 1'b0;
      de1_q   <= 1'b0;
      data1_q <= '0;
    end else begin
      vs1_q   <= i_vid_vsyn ~^ P_VS_POL;
      de1_q   <= i_vid_de;
      data1_q <= i_vid_data;
    end
  end

  vid_timing_meas #(
    .P_CNT_W(P_CNT_W)
  ) u_meas (
    .i_src_clk  (i_src_clk),
    .i_rst_n    (i_rst_n),
    .i_vs       (vs1_q),
    .i_de       (de1_q),
    .o_vs_fall  (vs_fall),
    .o_x        (x),
    .o_y        (y),
    .o_h_active (o_h_active),
    .o_v_active (o_v_active),
    .o_frame_err(o_frame_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (vs_fall && i_enable) state_d = S_PASS;
      S_PASS:  if (vs_fall && !i_enable) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // One extra bit on the window end so oversize windows clip instead of wrapping.
  assign x_end  = {1'b0, xs_q} + {1'b0, xsz_q};
  assign y_end  = {1'b0, ys_q} + {1'b0, ysz_q};
  assign in_win = (x >= xs_q) && ({1'b0, x} < x_end) && (y >= ys_q) && ({1'b0, y} < y_end);
  assign de_win = de1_q && in_win && (state_q == S_PASS);

  always_ff @(posedge i_src_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_WAIT;
      xs_q       <= '0;
      xsz_q      <= '0;
      ys_q       <= '0;
      ysz_q      <= '0;
      o_src_vsyn <= 1'b0;
      o_src_de   <= 1'b0;
      o_src_data <= '0;
    end else begin
      state_q <= state_d;
      if (vs_fall) begin
        xs_q  <= i_x_start;
        xsz_q <= i_x_size;
        ys_q  <= i_y_start;
        ysz_q <= i_y_size;
      end
      o_src_vsyn <= vs1_q;
      o_src_de   <= de_win;
      o_src_data <= de_win ? data1_q : '0;
    end
  end

  assign o_frame_active = (state_q == S_PASS);

endmodule

// File: tb/tb_src_video_window.sv
// Randomised and directed frames on an active-high and an active-low vsync build,
// checked every cycle against a frame/line/pixel-level reference model.
module tb_src_video_window;

  localparam int CMAX = 4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_act = 1'b0, vs_low;
  logic        de = 1'b0;
  logic [23:0] data = '0;
  logic        en = 1'b0;
  logic [11:0] xs = '0, xsz = '0, ys = '0, ysz = '0;

  logic        p_vs, p_de, p_fa, p_err, n_vs, n_de, n_fa, n_err;
  logic [23:0] p_data, n_data;
  logic [11:0] p_h, p_v, n_h, n_v;
  logic [51:0] act_p, act_n;

  assign vs_low = ~vs_act;
  assign act_p  = {p_vs, p_de, p_data, p_fa, p_h, p_v, p_err};
  assign act_n  = {n_vs, n_de, n_data, n_fa, n_h, n_v, n_err};

  always #5 clk = ~clk;

  src_video_window #(.P_VS_POL(1'b1)) dut_p (
    .i_src_clk(clk), .i_rst_n(rst_n), .i_vid_vsyn(vs_act), .i_vid_de(de), .i_vid_data(data),
    .i_enable(en), .i_x_start(xs), .i_x_size(xsz), .i_y_start(ys), .i_y_size(ysz),
    .o_src_vsyn(p_vs), .o_src_de(p_de), .o_src_data(p_data), .o_frame_active(p_fa),
    .o_h_active(p_h), .o_v_active(p_v), .o_frame_err(p_err)
  );

  src_video_window #(.P_VS_POL(1'b0)) dut_n (
    .i_src_clk(clk), .i_rst_n(rst_n), .i_vid_vsyn(vs_low), .i_vid_de(de), .i_vid_data(data),
    .i_enable(en), .i_x_start(xs), .i_x_size(xsz), .i_y_start(ys), .i_y_size(ysz),
    .o_src_vsyn(n_vs), .o_src_de(n_de), .o_src_data(n_data), .o_frame_active(n_fa),
    .o_h_active(n_h), .o_v_active(n_v), .o_frame_err(n_err)
  );

  typedef struct packed {
    logic        vs;
    logic        de;
    logic [23:0] px;
    logic        fa;
    logic [11:0] h;
    logic [11:0] v;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_chk;
  int   n_checks = 0, n_fail = 0;
  int   de_cnt = 0;
  logic [23:0] first_d = '0, last_d = '0;

  // Reference model: capture flag and window of the current frame, last measurement.
  bit  m_cap = 0, m_err = 0, prev_vs = 0;
  int  m_xs = 0, m_xsz = 0, m_ys = 0, m_ysz = 0, m_h = 0, m_v = 0;
  int  lens[$];
  int  nx_en = 0, nx_xs = 0, nx_xsz = 0, nx_ys = 0, nx_ysz = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  function automatic bit in_win(input int col, input int ln);
    int c = sat(col);
    int l = sat(ln);
    return (c >= m_xs) && (c < m_xs + m_xsz) && (l >= m_ys) && (l < m_ys + m_ysz);
  endfunction

  always @(posedge clk) begin
    #2;
    if (rst_n && exp_q.size() == 2) begin
      e_chk = exp_q.pop_front();
      chk("cycle_pos_pol", 64'(act_p), 64'(e_chk));
      chk("cycle_neg_pol", 64'(act_n), 64'(e_chk));
      if (p_de) begin
        if (de_cnt == 0) first_d = p_data;
        last_d = p_data;
        de_cnt++;
      end
    end
  end

  task automatic step(input bit vsv, input bit dv, input logic [23:0] px, input int col,
                      input int ln);
    bit   ode;
    exp_t e_new;
    @(negedge clk);
    vs_act = vsv;
    de     = dv;
    data   = dv ? px : 24'($urandom);
    if (!vsv && prev_vs) begin
      m_cap = en;
      m_xs  = int'(xs);
      m_xsz = int'(xsz);
      m_ys  = int'(ys);
      m_ysz = int'(ysz);
      lens.delete();
    end
    if (vsv && !prev_vs) begin
      m_v   = sat(lens.size());
      m_h   = (lens.size() > 0) ? sat(lens[lens.size()-1]) : 0;
      m_err = 0;
      foreach (lens[k]) if (sat(lens[k]) != sat(lens[0])) m_err = 1;
    end
    prev_vs = vsv;
    ode   = dv && m_cap && in_win(col, ln);
    e_new = {vsv, ode, ode ? px : 24'h0, m_cap, 12'(m_h), 12'(m_v), m_err};
    exp_q.push_back(e_new);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    vs_act = 1'b0;
    de     = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_pos_pol", 64'(act_p), 64'h0);
    chk("reset_neg_pol", 64'(act_n), 64'h0);
    m_cap = 0; m_err = 0; prev_vs = 0;
    m_xs = 0; m_xsz = 0; m_ys = 0; m_ysz = 0; m_h = 0; m_v = 0;
    lens.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_next(input int e, input int a, input int b, input int c, input int d);
    nx_en = e; nx_xs = a; nx_xsz = b; nx_ys = c; nx_ysz = d;
  endtask

  task automatic apply_next();
    en = 1'(nx_en); xs = 12'(nx_xs); xsz = 12'(nx_xsz); ys = 12'(nx_ys); ysz = 12'(nx_ysz);
  endtask

  // Frame = active lines, blanking, then a vsync pulse whose trailing edge starts the next.
  task automatic run_frame(input int w, input int h, input int short_ln, input bit tight,
                           input int rst_ln, input bit enc);
    int len;
    de_cnt = 0;
    for (int j = 0; j < h; j++) begin
      if (j == h / 2) apply_next();
      if (j == rst_ln) begin
        do_reset();
        return;
      end
      len = (j == short_ln) ? w - 1 : w;
      for (int i = 0; i < len; i++) step(1'b0, 1'b1, enc ? 24'((j << 12) | i) : 24'($urandom), i, j);
      lens.push_back(len);
      if (!(tight && j == h - 1)) repeat (3) step(1'b0, 1'b0, 24'h0, 0, 0);
    end
    if (h == 0) apply_next();
    if (!tight) repeat (2) step(1'b0, 1'b0, 24'h0, 0, 0);
    repeat (3) step(1'b1, 1'b0, 24'h0, 0, 0);
    repeat (3) step(1'b0, 1'b0, 24'h0, 0, 0);
  endtask

  task automatic frame_chk(input string tag, input int e_de, input int e_h, input int e_v,
                           input int e_err, input int e_fa);
    chk({tag, "_de_count"}, 64'(de_cnt), 64'(e_de));
    chk({tag, "_h_active"}, 64'(p_h), 64'(e_h));
    chk({tag, "_v_active"}, 64'(p_v), 64'(e_v));
    chk({tag, "_frame_err"}, 64'(p_err), 64'(e_err));
    chk({tag, "_frame_active"}, 64'(p_fa), 64'(e_fa));
  endtask

  initial begin
    do_reset();

    set_next(1, 0, 32, 0, 6);
    run_frame(32, 6, -1, 0, -1, 0);
    frame_chk("first_after_reset", 0, 32, 6, 0, 1);

    set_next(1, 100, 40, 10, 4);
    run_frame(32, 6, -1, 0, -1, 0);
    frame_chk("full_window", 192, 32, 6, 0, 1);

    set_next(1, 0, 64, 0, 4);
    run_frame(160, 16, -1, 0, -1, 1);
    frame_chk("crop_100_40_10_4", 160, 160, 16, 0, 1);
    chk("crop_first_px", 64'(first_d), 64'h00A064);
    chk("crop_last_px", 64'(last_d), 64'h00D08B);

    set_next(1, 32, 64, 0, 4);
    run_frame(96, 4, -1, 0, -1, 1);
    frame_chk("old_window_kept", 256, 96, 4, 0, 1);
    chk("old_window_first_px", 64'(first_d), 64'h000000);
    chk("old_window_last_px", 64'(last_d), 64'h00303F);

    set_next(0, 0, 64, 0, 8);
    run_frame(96, 4, -1, 0, -1, 1);
    frame_chk("new_window_en_drop", 256, 96, 4, 0, 0);
    chk("new_window_first_px", 64'(first_d), 64'h000020);
    chk("new_window_last_px", 64'(last_d), 64'h00305F);

    set_next(1, 0, 64, 0, 8);
    run_frame(64, 4, -1, 0, -1, 0);
    frame_chk("disabled_frame", 0, 64, 4, 0, 1);

    set_next(1, 0, 0, 0, 8);
    run_frame(64, 5, 2, 0, -1, 0);
    frame_chk("short_line", 319, 64, 5, 1, 1);

    set_next(1, 4000, 200, 0, 2);
    run_frame(64, 5, -1, 0, -1, 0);
    frame_chk("x_size_zero_clean", 0, 64, 5, 0, 1);

    set_next(1, 0, 16, 0, 16);
    run_frame(4100, 2, -1, 0, -1, 0);
    frame_chk("clip_4000_200", 200, 4095, 2, 0, 1);

    set_next(1, 0, 32, 0, 8);
    run_frame(16, 3, -1, 1, -1, 0);
    frame_chk("de_fall_with_vs_rise", 48, 16, 3, 0, 1);

    set_next(1, 0, 32, 0, 8);
    run_frame(0, 0, -1, 0, -1, 0);
    frame_chk("no_de_frame", 0, 0, 0, 0, 1);

    run_frame(32, 8, -1, 0, 3, 0);
    set_next(1, 0, 32, 0, 4);
    run_frame(32, 4, -1, 0, -1, 0);
    frame_chk("after_mid_reset", 0, 32, 4, 0, 1);

    for (int f = 0; f < 16; f++) begin
      int w  = $urandom_range(48, 1);
      int h  = $urandom_range(10, 0);
      int sh = (w >= 2 && $urandom_range(2, 0) == 0) ? $urandom_range(9, 0) : -1;
      set_next(($urandom_range(3, 0) != 0) ? 1 : 0, $urandom_range(50, 0), $urandom_range(50, 0),
               $urandom_range(12, 0), $urandom_range(12, 0));
      run_frame(w, h, sh, 1'($urandom_range(1, 0)), -1, 0);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
